// File: rtl/jtsdram_video_bars_pkg.sv
// Shared types for the SDRAM test status screen: error-count width and the
// pixel classes produced by the colour priority encoder.
package jtsdram_video_bars_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [2:0] {
    PIX_BLANK  = 3'd0,
    PIX_SEP    = 3'd1,
    PIX_BAR    = 3'd2,
    PIX_LIVE   = 3'd3,
    PIX_STICKY = 3'd4,
    PIX_OK     = 3'd5
  } pix_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jtsdram_errcnt.sv
// Per-bank error tracker: rising-edge detector on the live mismatch flag,
// sticky flag and saturating event counter.
module jtsdram_errcnt
  import jtsdram_video_bars_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bad,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  logic bad_dly;
  logic rise;

  assign rise = bad & ~bad_dly;

  // a clear coinciding with a new event keeps that event counted
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_dly <= 1'b0;
      sticky  <= 1'b0;
      cnt     <= '0;
    end else begin
      bad_dly <= bad;
      sticky  <= bad | (sticky & ~clr);
      if (clr)
        cnt <= {{(CNT_W-1){1'b0}}, rise};
      else if (rise)
        cnt <= sat_inc(cnt);
      else
        cnt <= cnt;
    end
  end

endmodule

// File: rtl/jtsdram_video_bars.sv
// SDRAM test status screen: one horizontal band per bank showing live/sticky
// state plus a red bar whose length is the bank's error-event count.
module jtsdram_video_bars
  import jtsdram_video_bars_pkg::*;
#(
  parameter int BANKS = 4,
  parameter int VW    = 8,
  parameter int CW    = 4,
  parameter int BLINK = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LVBL,
  input  logic             LHBL,
  input  logic [VW-1:0]    vdump,
  input  logic [8:0]       hdump,
  input  logic             dwnld_busy,
  input  logic             clr_err,
  input  logic [BANKS-1:0] bad,
  output logic [CW-1:0]    red,
  output logic [CW-1:0]    green,
  output logic [CW-1:0]    blue,
  output logic             any_bad
);

  localparam int BW = $clog2(BANKS);
  localparam logic [CW-1:0] MAXC = {CW{1'b1}};
  localparam logic [CW-1:0] HALF = MAXC >> 1;

  logic [BANKS-1:0] sticky;
  logic [CNT_W-1:0] cnt [BANKS];

  logic             LVBL_l;
  logic [BLINK-1:0] fcnt;
  logic             blink;

  logic [BW-1:0]    band;
  logic             first_line;
  logic [CNT_W-1:0] band_cnt;
  pix_e             pix;
  logic [CW-1:0]    r_nx, g_nx, b_nx;
  logic             unused;

  assign unused = hdump[8];

  generate
    for (genvar i = 0; i < BANKS; i++) begin : g_bank
      jtsdram_errcnt u_errcnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_err),
        .bad    (bad[i]),
        .sticky (sticky[i]),
        .cnt    (cnt[i])
      );
    end
  endgenerate

  // frame counter advances on each falling edge of LVBL
  always_ff @(posedge clk) begin
    if (rst) begin
      LVBL_l <= 1'b1;
      fcnt   <= '0;
    end else begin
      LVBL_l <= LVBL;
      if (LVBL_l && !LVBL)
        fcnt <= fcnt + 1'b1;
      else
        fcnt <= fcnt;
    end
  end

  assign blink = fcnt[BLINK-1];

  // pixel class in priority order: blank, separator, bar, live, sticky, ok
  always_comb begin
    band       = vdump[VW-1 -: BW];
    first_line = (vdump[VW-BW-1:0] == '0);
    band_cnt   = cnt[band];
    pix        = PIX_OK;
    if (!LHBL || !LVBL)
      pix = PIX_BLANK;
    else if (first_line)
      pix = PIX_SEP;
    else if (hdump[7:0] < band_cnt)
      pix = PIX_BAR;
    else if (bad[band])
      pix = PIX_LIVE;
    else if (sticky[band])
      pix = PIX_STICKY;
    else
      pix = PIX_OK;
  end

  // colour mapping; download dims everything except blanking and separators
  always_comb begin
    r_nx = '0;
    g_nx = '0;
    b_nx = '0;
    case (pix)
      PIX_BLANK:  begin r_nx = '0;   g_nx = '0;   b_nx = '0;   end
      PIX_SEP:    begin r_nx = MAXC; g_nx = MAXC; b_nx = MAXC; end
      PIX_BAR:    begin r_nx = MAXC; g_nx = '0;   end
      PIX_LIVE:   begin r_nx = MAXC; g_nx = '0;   end
      PIX_STICKY: begin r_nx = MAXC; g_nx = HALF; end
      PIX_OK:     begin r_nx = '0;   g_nx = MAXC; end
      default:    begin r_nx = '0;   g_nx = '0;   b_nx = '0;   end
    endcase
    if (dwnld_busy && pix != PIX_BLANK && pix != PIX_SEP) begin
      r_nx = r_nx >> 1;
      g_nx = g_nx >> 1;
      b_nx = blink ? HALF : '0;
    end else begin
      b_nx = b_nx;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      any_bad <= 1'b0;
    end else begin
      red     <= r_nx;
      green   <= g_nx;
      blue    <= b_nx;
      any_bad <= |sticky;
    end
  end

endmodule

// File: tb/tb_jtsdram_video_bars.sv
// Bench for jtsdram_video_bars: directed scenarios followed by random traffic,
// all checked against an arithmetic reference model of the status screen.
module tb_jtsdram_video_bars;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       LVBL = 1'b1, LHBL = 1'b1;
  logic [7:0] vdump = 8'h41;
  logic [8:0] hdump = 9'd0;
  logic       dwnld_busy = 1'b0, clr_err = 1'b0;
  logic [3:0] bad = 4'h0;
  logic [3:0] red, green, blue;
  logic       any_bad;

  int checks = 0, failures = 0;

  // reference state
  int m_cnt [4];
  bit m_sticky [4];
  bit m_prev [4];
  int m_fcnt;
  bit m_lvbl_prev;

  always #5 clk = ~clk;

  jtsdram_video_bars dut (
    .clk(clk), .rst(rst), .LVBL(LVBL), .LHBL(LHBL), .vdump(vdump), .hdump(hdump),
    .dwnld_busy(dwnld_busy), .clr_err(clr_err), .bad(bad),
    .red(red), .green(green), .blue(blue), .any_bad(any_bad)
  );

  function automatic logic [11:0] model_pix();
    int b, r, g, bl, col;
    b   = vdump / 64;
    col = hdump % 256;
    if (!LHBL || !LVBL) return 12'h000;
    if (vdump % 64 == 0) return 12'hFFF;
    if (col < m_cnt[b])       begin r = 15; g = 0;  end
    else if (bad[b])          begin r = 15; g = 0;  end
    else if (m_sticky[b])     begin r = 15; g = 7;  end
    else                      begin r = 0;  g = 15; end
    bl = 0;
    if (dwnld_busy) begin
      r  = r / 2;
      g  = g / 2;
      bl = (m_fcnt >= 16) ? 7 : 0;
    end
    return {r[3:0], g[3:0], bl[3:0]};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [11:0] exp_rgb;
    logic        exp_any;
    exp_any = 1'b0;
    if (rst) exp_rgb = 12'h000;
    else begin
      exp_rgb = model_pix();
      for (int i = 0; i < 4; i++) exp_any = exp_any | m_sticky[i];
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_sticky[i] = 0; m_prev[i] = 0; end
      m_fcnt = 0;
      m_lvbl_prev = 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit ev;
        ev = bad[i] && !m_prev[i];
        if (clr_err) m_cnt[i] = ev ? 1 : 0;
        else if (ev && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        if (bad[i]) m_sticky[i] = 1;
        else if (clr_err) m_sticky[i] = 0;
        m_prev[i] = bad[i];
      end
      if (m_lvbl_prev && !LVBL) m_fcnt = (m_fcnt + 1) % 32;
      m_lvbl_prev = LVBL;
    end
    #1;
    check("rgb", {red, green, blue}, exp_rgb);
    check("any_bad", {11'd0, any_bad}, {11'd0, exp_any});
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_sticky[i] = 0; m_prev[i] = 0; end
    m_fcnt = 0;
    m_lvbl_prev = 1;

    // 1: reset then a healthy pixel
    tick();
    rst = 1'b0;
    tick();
    check("t1_healthy", {red, green, blue}, 12'h0F0);
    check("t1_any_bad", {11'd0, any_bad}, 12'h000);

    // 2: three pulses on bank 2
    for (int k = 0; k < 3; k++) begin
      bad = 4'h4; tick();
      bad = 4'h0; tick();
    end
    tick();
    check("t2_any_bad", {11'd0, any_bad}, 12'h001);
    vdump = 8'h90; hdump = 9'd2; tick();
    check("t2_bar_end", {red, green, blue}, 12'hF00);
    hdump = 9'd3; tick();
    check("t2_amber", {red, green, blue}, 12'hF70);

    // 3: 300 pulses on bank 1 saturate, then clear with coincident edge
    for (int k = 0; k < 300; k++) begin
      bad = 4'h2; tick();
      bad = 4'h0; tick();
    end
    vdump = 8'h50; hdump = 9'd254; tick();
    check("t3_sat_254", {red, green, blue}, 12'hF00);
    hdump = 9'd255; tick();
    check("t3_sat_255", {red, green, blue}, 12'hF70);
    clr_err = 1'b1; bad = 4'h2; tick();
    clr_err = 1'b0; bad = 4'h0; hdump = 9'd0; tick();
    check("t3_clr_cnt1", {red, green, blue}, 12'hF00);
    hdump = 9'd1; tick();
    check("t3_clr_sticky", {red, green, blue}, 12'hF70);

    // 4: separator and horizontal blank
    vdump = 8'hC0; tick();
    check("t4_sep", {red, green, blue}, 12'hFFF);
    LHBL = 1'b0; tick();
    check("t4_hblank", {red, green, blue}, 12'h000);
    LHBL = 1'b1;

    // 5: download dimming and blink after 16 frames
    dwnld_busy = 1'b1; vdump = 8'h2A; hdump = 9'd100;
    for (int k = 0; k < 16; k++) begin
      LVBL = 1'b0; tick();
      LVBL = 1'b1; tick();
      if (k == 14) check("t5_no_blink", {red, green, blue}, 12'h070);
    end
    check("t5_blink", {red, green, blue}, 12'h077);
    dwnld_busy = 1'b0;

    // 6: reset mid-line with everything failing
    bad = 4'hF; hdump = 9'd5; vdump = 8'h85; tick();
    tick();
    rst = 1'b1; tick();
    check("t6_rgb", {red, green, blue}, 12'h000);
    check("t6_any_bad", {11'd0, any_bad}, 12'h000);
    rst = 1'b0; bad = 4'h0; hdump = 9'd0; tick();
    check("t6_no_bar", {red, green, blue}, 12'h0F0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 299) == 0);
      clr_err    = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 4; i++) bad[i] = ($urandom_range(0, 3) == 0);
      vdump      = 8'($urandom);
      hdump      = $urandom_range(0, 1) ? 9'($urandom_range(0, 40)) : 9'($urandom);
      LHBL       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) LVBL = ~LVBL;
      if ($urandom_range(0, 99) == 0) dwnld_busy = ~dwnld_busy;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
